// File: rtl/mem_guard.sv
// Memory access guard: latches a request, runs it past the PMP checker, then the bus.
// Optional macro BUS_TIMEOUT_EN aborts a bus access after TIMEOUT_CYCLES wait cycles.
//
// state  | meaning
// IDLE   | no request in flight; accepts mem_valid or drains the pending entry
// CHECK  | req_* presented to PMP for one cycle
// ACCESS | bus_valid held until bus_ready (or timeout when enabled)
// DONE   | one-cycle mem_ready with read data
// FAULT  | one-cycle mem_ready with mem_error, data forced to zero
module mem_guard #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [1:0]  mem_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        req_instr,
  output logic [1:0]  req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic        pmp_valid,
  input  logic        pmp_error,
  output logic        bus_valid,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  typedef struct packed {
    logic        instr;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state_q, state_d;
  req_t        mem_req, req_q, pend_q, req_next;
  logic        pend_valid_q, overflow_q;
  logic [31:0] rdata_q;

  logic        in_exit;
  logic        new_direct;
  logic        pend_take;
  logic        pend_cap;
  logic        req_drop;
  logic        req_load;
  logic        timeout_hit;

  assign mem_req = {mem_instr, mem_mode, mem_addr, mem_wdata, mem_wstrb};

  // The pending entry drains whenever the FSM can start a new CHECK; a strobe in that
  // same cycle refills the buffer instead of being dropped.
  assign in_exit    = (state_q == S_DONE) || (state_q == S_FAULT);
  assign pend_take  = pend_valid_q && (in_exit || (state_q == S_IDLE));
  assign new_direct = mem_valid && (state_q == S_IDLE) && !pend_valid_q;
  assign pend_cap   = mem_valid && !new_direct && (!pend_valid_q || pend_take);
  assign req_drop   = mem_valid && pend_valid_q && !pend_take;
  assign req_load   = new_direct || pend_take;
  assign req_next   = pend_take ? pend_q : mem_req;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (state_q != S_ACCESS) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_load) state_d = S_CHECK;
      S_CHECK:  state_d = pmp_error ? S_FAULT : S_ACCESS;
      S_ACCESS: begin
        // bus_ready in the final timeout cycle still completes normally
        if (bus_ready)        state_d = S_DONE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DONE,
      S_FAULT:  state_d = pend_valid_q ? S_CHECK : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    pmp_valid = 1'b0;
    bus_valid = 1'b0;
    case (state_q)
      S_CHECK:  pmp_valid = 1'b1;
      S_ACCESS: bus_valid = 1'b1;
      S_DONE: begin
        mem_ready = 1'b1;
        mem_rdata = rdata_q;
      end
      S_FAULT: begin
        mem_ready = 1'b1;
        mem_error = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
    end else if (req_load) begin
      req_q <= req_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else if (pend_cap) begin
      pend_q       <= mem_req;
      pend_valid_q <= 1'b1;
    end else if (pend_take) begin
      pend_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (req_drop) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if ((state_q == S_ACCESS) && bus_ready) begin
      rdata_q <= bus_rdata;
    end
  end

  assign req_instr = req_q.instr;
  assign req_mode  = req_q.mode;
  assign req_addr  = req_q.addr;
  assign req_wdata = req_q.wdata;
  assign req_wstrb = req_q.wstrb;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mem_guard.sv
// Bench for mem_guard: table of single transactions plus hand-written pending,
// reset and bus-timeout sequences; completions checked against a scoreboard queue.
module tb_mem_guard;

  localparam int TIMEOUT_CYCLES = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [1:0]  mem_mode = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        req_instr;
  logic [1:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        pmp_valid;
  logic        pmp_error = 1'b0;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'hBAD0_BAD0;
  logic        overflow;

  mem_guard #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .req_instr(req_instr), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .pmp_valid(pmp_valid), .pmp_error(pmp_error),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        instr;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        pmp_err;
    int          wait_n;
    logic [31:0] bus_data;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input vec_t v);
    mem_valid = 1'b1;
    mem_instr = v.instr;
    mem_mode  = v.mode;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wstrb;
  endtask

  // Completion monitor: every mem_ready must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && mem_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ready: got mem_ready=1 want none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_cycle", 80'(cyc), 80'(e.cyc));
        check("mem_error", 80'(mem_error), 80'(e.err));
        check("mem_rdata", 80'(mem_rdata), 80'(e.rdata));
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int n;
    int bv;
    step();
    strobe(v);
    n = cyc;
    sb.push_back('{v.exp_err, v.exp_rdata, v.pmp_err ? n + 2 : n + 3 + v.wait_n});
    step();
    mem_valid = 1'b0;
    pmp_error = v.pmp_err;
    check("pmp_valid", 80'(pmp_valid), 80'(1));
    check("req_fields", 80'({req_instr, req_mode, req_addr, req_wdata, req_wstrb}),
          80'({v.instr, v.mode, v.addr, v.wdata, v.wstrb}));
    step();
    pmp_error = 1'b0;
    check("pmp_one_cycle", 80'(pmp_valid), 80'(0));
    if (v.pmp_err) begin
      check("fault_no_bus", 80'(bus_valid), 80'(0));
      step();
    end else begin
      bv = 0;
      for (int w = 0; w < v.wait_n; w++) begin
        bv += int'(bus_valid);
        step();
      end
      bus_ready = 1'b1;
      bus_rdata = v.bus_data;
      bv += int'(bus_valid);
      step();
      bus_ready = 1'b0;
      bus_rdata = 32'hBAD0_BAD0;
      check("bus_valid_cycles", 80'(bv), 80'(v.wait_n + 1));
      check("done_bus_idle", 80'(bus_valid), 80'(0));
      step();
    end
  endtask

  initial begin
    vec_t tbl[6];
    vec_t va, vb, vc;
    int   n;
    int   bv;

    tbl[0] = '{1'b0, 2'd0, 32'h0000_1000, 32'h0,         4'h0, 1'b0, 0,   32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    tbl[1] = '{1'b0, 2'd1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 1'b1, 0,   32'h0,         1'b1, 32'h0};
    tbl[2] = '{1'b1, 2'd3, 32'h2000_0004, 32'h0,         4'h0, 1'b0, 2,   32'h1234_5678, 1'b0, 32'h1234_5678};
    tbl[3] = '{1'b0, 2'd2, 32'h0000_0010, 32'h5555_AAAA, 4'h3, 1'b0, 1,   32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
    tbl[4] = '{1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 0,   32'h0,         1'b1, 32'h0};
    tbl[5] = '{1'b0, 2'd3, 32'h0000_2000, 32'h0,         4'h0, 1'b0, 255, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};

    repeat (3) step();
    check("rst_mem_ready", 80'(mem_ready), 80'(0));
    check("rst_mem_error", 80'(mem_error), 80'(0));
    check("rst_mem_rdata", 80'(mem_rdata), 80'(0));
    check("rst_bus_valid", 80'(bus_valid), 80'(0));
    check("rst_pmp_valid", 80'(pmp_valid), 80'(0));
    check("rst_req", 80'({req_instr, req_mode, req_addr, req_wdata, req_wstrb}), 80'(0));
    check("rst_overflow", 80'(overflow), 80'(0));
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Back-to-back strobes A, B, C with a 3-wait bus: B pends, C is dropped.
    va = '{1'b0, 2'd0, 32'h0000_A000, 32'h0, 4'h0, 1'b0, 3, 32'h1111_1111, 1'b0, 32'h1111_1111};
    vb = '{1'b0, 2'd0, 32'h0000_B000, 32'h0, 4'h0, 1'b0, 0, 32'h2222_2222, 1'b0, 32'h2222_2222};
    vc = '{1'b0, 2'd0, 32'h0000_C000, 32'h0, 4'h0, 1'b0, 0, 32'h3333_3333, 1'b0, 32'h3333_3333};
    check("ovf_before", 80'(overflow), 80'(0));
    step();
    strobe(va);
    n = cyc;
    sb.push_back('{1'b0, 32'h1111_1111, n + 6});
    step();
    strobe(vb);
    step();
    strobe(vc);
    step();
    mem_valid = 1'b0;
    check("ovf_set", 80'(overflow), 80'(1));
    check("req_stable_a", 80'(req_addr), 80'(32'h0000_A000));
    step();
    step();
    bus_ready = 1'b1;
    bus_rdata = 32'h1111_1111;
    step();
    bus_ready = 1'b0;
    check("done_req_a", 80'(req_addr), 80'(32'h0000_A000));
    step();
    check("b_check", 80'(pmp_valid), 80'(1));
    check("b_req_addr", 80'(req_addr), 80'(32'h0000_B000));
    sb.push_back('{1'b0, 32'h2222_2222, n + 9});
    step();
    bus_ready = 1'b1;
    bus_rdata = 32'h2222_2222;
    step();
    bus_ready = 1'b0;
    step();
    check("c_dropped_pmp", 80'(pmp_valid), 80'(0));
    step();
    check("c_dropped_bus", 80'(bus_valid), 80'(0));
    check("ovf_sticky", 80'(overflow), 80'(1));

    // Reset while waiting on the bus.
    step();
    strobe(va);
    step();
    mem_valid = 1'b0;
    step();
    check("pre_rst_bus", 80'(bus_valid), 80'(1));
    step();
    reset = 1'b0;
    #1;
    check("rst_async_bus", 80'(bus_valid), 80'(0));
    check("rst_async_req", 80'(req_addr), 80'(0));
    check("rst_async_ovf", 80'(overflow), 80'(0));
    check("rst_async_ready", 80'(mem_ready), 80'(0));
    step();
    reset = 1'b1;
    bv = 0;
    for (int k = 0; k < 6; k++) begin
      bv += int'(bus_valid) + int'(pmp_valid);
      step();
    end
    check("post_rst_idle", 80'(bv), 80'(0));

    // Bus that never answers.
    step();
    strobe(tbl[0]);
    n = cyc;
    step();
    mem_valid = 1'b0;
    step();
`ifdef BUS_TIMEOUT_EN
    sb.push_back('{1'b1, 32'h0, n + 2 + TIMEOUT_CYCLES});
    bv = 0;
    for (int k = 0; k < 2000 && !mem_ready; k++) begin
      bv += int'(bus_valid);
      step();
    end
    check("timeout_bus_cycles", 80'(bv), 80'(TIMEOUT_CYCLES));
    check("timeout_fault", 80'(mem_error), 80'(1));
    step();
`else
    bv = 0;
    for (int k = 0; k < 1000; k++) begin
      bv += int'(bus_valid);
      step();
    end
    check("no_timeout_cycles", 80'(bv), 80'(1000));
    check("still_waiting", 80'(bus_valid), 80'(1));
    bus_ready = 1'b1;
    bus_rdata = 32'h7777_0001;
    sb.push_back('{1'b0, 32'h7777_0001, cyc + 1});
    step();
    bus_ready = 1'b0;
    step();
`endif

    repeat (3) step();
    check("scoreboard_empty", 80'(sb.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish by 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_guard.md
MEM_GUARD -- requirements
Module: mem_guard

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, bus wait cycles before abort; only used with BUS_TIMEOUT_EN.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 resets immediately.
REQ-004 mem_valid  in  1  one-cycle request strobe from fetch/LSU.
REQ-005 mem_instr  in  1  1 = instruction fetch.
REQ-006 mem_mode  in  2  privilege mode of request.
REQ-007 mem_addr  in  32  byte address.
REQ-008 mem_wdata  in  32  store data.
REQ-009 mem_wstrb  in  4  byte strobes; 0 = read.
REQ-010 mem_ready  out  1  one-cycle completion pulse.
REQ-011 mem_rdata  out  32  read data, valid with mem_ready.
REQ-012 mem_error  out  1  access fault, valid with mem_ready.
REQ-013 req_instr, req_mode, req_addr, req_wdata, req_wstrb  out  1/2/32/32/4  latched request, shared by PMP check and bus.
REQ-014 pmp_valid  out  1  latched request presented to PMP checker.
REQ-015 pmp_error  in  1  combinational PMP verdict for req_* fields.
REQ-016 bus_valid  out  1  bus request, held until bus_ready.
REQ-017 bus_ready  in  1  bus completion.
REQ-018 bus_rdata  in  32  bus read data, valid with bus_ready.

Function
REQ-019 FSM states: IDLE, CHECK, ACCESS, DONE, FAULT.
REQ-020 IDLE: mem_valid=1 latches all mem_* fields into req_* and moves to CHECK.
REQ-021 CHECK: pmp_valid=1 for exactly one cycle; pmp_error=1 -> FAULT, else -> ACCESS.
REQ-022 ACCESS: bus_valid=1 every cycle; bus_ready=1 captures bus_rdata into mem_rdata and moves to DONE.
REQ-023 DONE: mem_ready=1, mem_error=0 for one cycle. FAULT: mem_ready=1, mem_error=1, mem_rdata=0 for one cycle. Both exit to IDLE, or directly to CHECK if the pending buffer is full.
REQ-024 Latency with zero-wait bus: strobe in cycle N, bus_valid in N+2, mem_ready in N+3. Faulting access: mem_ready in N+2, bus_valid never asserted.
REQ-025 Pending buffer, one entry: mem_valid outside IDLE is captured if the buffer is empty.
REQ-026 A pending entry is loaded into req_* on exit from DONE/FAULT; the buffer then empties.
REQ-027 mem_valid while the buffer is full is dropped and sets sticky bit overflow; overflow clears only on reset.
REQ-028 mem_valid in the same cycle the pending entry is consumed is accepted into the buffer.
REQ-029 req_* are stable from CHECK through DONE/FAULT.
REQ-030 Stores and fetches follow the same path; a read is mem_wstrb=0.

Reset
REQ-031 reset=0 forces IDLE, empties the pending buffer and clears overflow.
REQ-032 reset=0 clears mem_ready, mem_error, mem_rdata, bus_valid, pmp_valid and all req_* to 0, asynchronously.
REQ-033 Reset during ACCESS drops bus_valid immediately; no mem_ready is issued for the aborted request.

Configuration
REQ-034 Macro BUS_TIMEOUT_EN: when defined, an 8+-bit counter clears on ACCESS entry and increments each ACCESS cycle.
REQ-035 With BUS_TIMEOUT_EN, if the count reaches TIMEOUT_CYCLES-1 without bus_ready: drop bus_valid and go to FAULT.
REQ-036 bus_ready arriving in the timeout cycle wins and goes to DONE.
REQ-037 Without BUS_TIMEOUT_EN: no counter; ACCESS waits indefinitely.

Verification
REQ-038 Read 0x00001000, pmp_error=0, bus_ready same cycle, bus_rdata=0xDEADBEEF -> mem_ready at N+3, mem_rdata=0xDEADBEEF, mem_error=0.
REQ-039 Store 0x80000000, wstrb=0xF, pmp_error=1 -> no bus_valid; mem_ready and mem_error at N+2, mem_rdata=0.
REQ-040 Strobe A, then strobe B in N+1, strobe C in N+2, bus 3-wait -> A completes, B enters CHECK the cycle after A's mem_ready, C dropped, overflow=1.
REQ-041 reset=0 mid-ACCESS -> bus_valid=0 same cycle; no mem_ready after release.
REQ-042 BUS_TIMEOUT_EN, bus_ready held 0 -> bus_valid for exactly 256 cycles, then mem_ready with mem_error=1. Without the macro, still waiting at cycle 1000.
